// File: rtl/bcd_to_bin_seq.sv
// Sequential 3-digit BCD to 10-bit binary converter using reverse double dabble (shift right, subtract 3).
// Optional BCD_DIGIT_CHECK_EN builds an ERR state that rejects any digit above 9.
module bcd_to_bin_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] bcd_in,
    output logic [9:0]  bin_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned BCD_W      = 12;
    localparam int unsigned BIN_W      = 10;
    localparam int unsigned WORK_W     = BCD_W + BIN_W;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned NUM_SHIFTS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_d;
    logic [WORK_W-1:0]   shifted_c;
    logic                digit_bad_c;

    // One reverse double-dabble step: shift right, then pull each digit field >= 8 back by 3.
    always_comb begin
        shifted_c = work_q >> 1;
        if (shifted_c[21:18] >= 4'd8) shifted_c[21:18] = shifted_c[21:18] - 4'd3;
        if (shifted_c[17:14] >= 4'd8) shifted_c[17:14] = shifted_c[17:14] - 4'd3;
        if (shifted_c[13:10] >= 4'd8) shifted_c[13:10] = shifted_c[13:10] - 4'd3;
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q;
    assign digit_bad_c = (bcd_in[11:8] > 4'd9) || (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
    assign err         = err_q;
`else
    assign digit_bad_c = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
        err_d   = err_q;
`else
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {bcd_in, BIN_W'(0)};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = digit_bad_c ? ERR : SHIFT;
                end
            end
            SHIFT: begin
                work_d = shifted_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NUM_SHIFTS - 1)) begin
                    bin_d   = shifted_c[BIN_W-1:0];
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
`ifdef BCD_DIGIT_CHECK_EN
            ERR: begin
                bin_d   = '0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    logic unused_c;
    assign unused_c = err_d;
`endif

    assign bin_out = bin_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
